// File: rtl/gng_ctrl_pkg.sv
// Shared types and constants for the GNG SNR sweep controller.
// Sigma words are S(8,7); the default table covers SNR 7..12 dB.
package gng_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] SNR_7DB  = 8'h1c;
  localparam logic [7:0] SNR_8DB  = 8'h19;
  localparam logic [7:0] SNR_9DB  = 8'h16;
  localparam logic [7:0] SNR_10DB = 8'h14;
  localparam logic [7:0] SNR_11DB = 8'h12;
  localparam logic [7:0] SNR_12DB = 8'h10;

  localparam int unsigned N_DEFAULT_POINTS = 6;

  // Entry 0 sits in the least significant byte.
  localparam logic [N_DEFAULT_POINTS*8-1:0] DEFAULT_SIGMA_TABLE =
    {SNR_12DB, SNR_11DB, SNR_10DB, SNR_9DB, SNR_8DB, SNR_7DB};

  function automatic logic [7:0] default_sigma(input int unsigned idx);
    if (idx < N_DEFAULT_POINTS) begin
      return DEFAULT_SIGMA_TABLE[idx*8 +: 8];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/gng_sigma_table.sv
// SNR point table: N_POINTS sigma words, synchronous write, asynchronous read,
// reset to the package default sweep.
module gng_sigma_table
  import gng_ctrl_pkg::*;
#(
  parameter int unsigned NBT_SIGMA = 8,
  parameter int unsigned N_POINTS  = 6,
  parameter int unsigned NB_IDX    = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_wr_en,
  input  logic [NB_IDX-1:0]    i_wr_addr,
  input  logic [NBT_SIGMA-1:0] i_wr_data,
  input  logic [NB_IDX-1:0]    i_rd_addr,
  output logic [NBT_SIGMA-1:0] o_rd_data_c
);

  logic [N_POINTS*NBT_SIGMA-1:0] r_mem;
  logic                          w_wr_ok;

  assign w_wr_ok = i_wr_en && (32'(i_wr_addr) < N_POINTS);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < N_POINTS; i++) begin
        r_mem[i*NBT_SIGMA +: NBT_SIGMA] <= NBT_SIGMA'(default_sigma(i));
      end
    end else if (w_wr_ok) begin
      r_mem[32'(i_wr_addr)*NBT_SIGMA +: NBT_SIGMA] <= i_wr_data;
    end
  end

  assign o_rd_data_c = r_mem[32'(i_rd_addr)*NBT_SIGMA +: NBT_SIGMA];

endmodule

// File: rtl/gng_snr_sweep_ctrl.sv
// Sweep sequencer for top_gng: loads each SNR point's sigma, waits for the
// pipeline to settle, then counts jointly-valid I/Q samples for the capture window.
module gng_snr_sweep_ctrl
  import gng_ctrl_pkg::*;
#(
  parameter int unsigned NBT_SIGMA  = 8,
  parameter int unsigned N_POINTS   = 6,
  parameter int unsigned NB_IDX     = 3,
  parameter int unsigned NB_CNT     = 24,
  parameter int unsigned N_SAMPLES  = 4000000,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_wr_en,
  input  logic [NB_IDX-1:0]    i_wr_addr,
  input  logic [NBT_SIGMA-1:0] i_wr_data,
  input  logic                 i_valid_I,
  input  logic                 i_valid_Q,
  output logic [NBT_SIGMA-1:0] o_sigma,
  output logic [NB_IDX-1:0]    o_point,
  output logic                 o_log_en,
  output logic                 o_point_done,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned       NB_SET      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [NB_SET-1:0] SETTLE_LAST = NB_SET'(SETTLE_CYC - 1);
  localparam logic [NB_CNT-1:0] SAMP_LAST   = NB_CNT'(N_SAMPLES - 1);
  localparam logic [NB_IDX-1:0] POINT_LAST  = NB_IDX'(N_POINTS - 1);

  // Parameter sanity, caught at elaboration.
  if (N_SAMPLES < 1) begin : g_chk_samples
    $error("gng_snr_sweep_ctrl: N_SAMPLES must be >= 1");
  end
  if (SETTLE_CYC < 1) begin : g_chk_settle
    $error("gng_snr_sweep_ctrl: SETTLE_CYC must be >= 1");
  end
  if (64'(N_SAMPLES) > ((64'd1 << NB_CNT) - 64'd1)) begin : g_chk_cnt
    $error("gng_snr_sweep_ctrl: NB_CNT too narrow for N_SAMPLES");
  end
  if ((64'd1 << NB_IDX) < 64'(N_POINTS)) begin : g_chk_idx
    $error("gng_snr_sweep_ctrl: NB_IDX too narrow for N_POINTS");
  end

  state_t               r_state;
  state_t               w_state_next;
  logic [NB_IDX-1:0]    r_point;
  logic [NB_IDX-1:0]    w_point_next;
  logic [NBT_SIGMA-1:0] r_sigma;
  logic [NBT_SIGMA-1:0] w_sigma_next;
  logic [NB_SET-1:0]    r_settle_cnt;
  logic [NB_SET-1:0]    w_settle_next;
  logic [NB_CNT-1:0]    r_samp_cnt;
  logic [NB_CNT-1:0]    w_samp_next;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_point_done;
  logic [NBT_SIGMA-1:0] w_tbl_sigma;
  logic                 w_joint_valid;

  gng_sigma_table #(
    .NBT_SIGMA (NBT_SIGMA),
    .N_POINTS  (N_POINTS),
    .NB_IDX    (NB_IDX)
  ) u_table (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .i_rd_addr   (r_point),
    .o_rd_data_c (w_tbl_sigma)
  );

  assign w_joint_valid = i_valid_I & i_valid_Q;

  // Next-state and datapath updates; abort overrides everything, including start.
  always_comb begin
    w_state_next  = r_state;
    w_point_next  = r_point;
    w_sigma_next  = r_sigma;
    w_settle_next = r_settle_cnt;
    w_samp_next   = r_samp_cnt;

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_next = ST_LOAD;
          w_point_next = '0;
        end
      end
      ST_LOAD: begin
        w_sigma_next  = w_tbl_sigma;
        w_settle_next = '0;
        w_state_next  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_samp_next  = '0;
          w_state_next = ST_COLLECT;
        end else begin
          w_settle_next = r_settle_cnt + NB_SET'(1);
        end
      end
      ST_COLLECT: begin
        if (w_joint_valid) begin
          if (r_samp_cnt == SAMP_LAST) begin
            w_state_next = ST_NEXT;
          end else begin
            w_samp_next = r_samp_cnt + NB_CNT'(1);
          end
        end
      end
      ST_NEXT: begin
        if (r_point == POINT_LAST) begin
          w_state_next = ST_DONE;
        end else begin
          w_point_next = r_point + NB_IDX'(1);
          w_state_next = ST_LOAD;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (i_abort) begin
      w_state_next = ST_IDLE;
      w_point_next = r_point;
      w_sigma_next = r_sigma;
    end
  end

  // State and output registers; status flags are registered from the next state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_point      <= '0;
      r_sigma      <= '0;
      r_settle_cnt <= '0;
      r_samp_cnt   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_point_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_point      <= w_point_next;
      r_sigma      <= w_sigma_next;
      r_settle_cnt <= w_settle_next;
      r_samp_cnt   <= w_samp_next;
      r_busy       <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
      r_done       <= (w_state_next == ST_DONE);
      r_point_done <= (w_state_next == ST_NEXT);
    end
  end

  assign o_sigma      = r_sigma;
  assign o_point      = r_point;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_point_done = r_point_done;
  assign o_log_en     = (r_state == ST_COLLECT) & w_joint_valid;

endmodule

// File: tb/tb_gng_snr_sweep_ctrl.sv
// Self-checking bench for gng_snr_sweep_ctrl with a short sweep (8 samples, 4 settle cycles).
// A scoreboard holds the expected (point, sigma) of every logged sample and every point_done.
module tb_gng_snr_sweep_ctrl;

  localparam int unsigned NBT_SIGMA  = 8;
  localparam int unsigned N_POINTS   = 6;
  localparam int unsigned NB_IDX     = 3;
  localparam int unsigned NB_CNT     = 24;
  localparam int unsigned N_SAMPLES  = 8;
  localparam int unsigned SETTLE_CYC = 4;

  localparam logic [47:0] DEF_TBL = {8'h10, 8'h12, 8'h14, 8'h16, 8'h19, 8'h1c};

  typedef struct packed {
    logic [NB_IDX-1:0]    point;
    logic [NBT_SIGMA-1:0] sigma;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 i_reset, i_start, i_abort, i_wr_en;
  logic [NB_IDX-1:0]    i_wr_addr;
  logic [NBT_SIGMA-1:0] i_wr_data;
  logic                 i_valid_I, i_valid_Q;
  logic [NBT_SIGMA-1:0] o_sigma;
  logic [NB_IDX-1:0]    o_point;
  logic                 o_log_en, o_point_done, o_busy, o_done;

  int          checks = 0;
  int          errors = 0;
  exp_t        q_log[$];
  logic [NB_IDX-1:0] q_done[$];
  logic [47:0] tb_tbl = DEF_TBL;
  exp_t        mon_e;
  logic [NB_IDX-1:0] mon_p;

  gng_snr_sweep_ctrl #(
    .NBT_SIGMA (NBT_SIGMA), .N_POINTS (N_POINTS), .NB_IDX (NB_IDX),
    .NB_CNT (NB_CNT), .N_SAMPLES (N_SAMPLES), .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .i_clock (clk), .i_reset (i_reset), .i_start (i_start), .i_abort (i_abort),
    .i_wr_en (i_wr_en), .i_wr_addr (i_wr_addr), .i_wr_data (i_wr_data),
    .i_valid_I (i_valid_I), .i_valid_Q (i_valid_Q),
    .o_sigma (o_sigma), .o_point (o_point), .o_log_en (o_log_en),
    .o_point_done (o_point_done), .o_busy (o_busy), .o_done (o_done)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every logged sample and point_done must match the queue head.
  always @(negedge clk) begin
    if (o_log_en === 1'b1) begin
      checks++;
      if (q_log.size() == 0) begin
        errors++;
        $display("FAIL log_unexpected: got point %0d sigma %h, expected no log", o_point, o_sigma);
      end else begin
        mon_e = q_log.pop_front();
        if (o_point !== mon_e.point || o_sigma !== mon_e.sigma) begin
          errors++;
          $display("FAIL log_sample: got point %0d sigma %h, expected point %0d sigma %h",
                   o_point, o_sigma, mon_e.point, mon_e.sigma);
        end
      end
    end
    if (o_point_done === 1'b1) begin
      checks++;
      if (q_done.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got point_done at point %0d, expected none", o_point);
      end else begin
        mon_p = q_done.pop_front();
        if (o_point !== mon_p) begin
          errors++;
          $display("FAIL point_done: got point %0d expected %0d", o_point, mon_p);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_point(input int p, input int n, input bit with_done);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.point = NB_IDX'(p);
      e.sigma = tb_tbl[p*8 +: 8];
      q_log.push_back(e);
    end
    if (with_done) q_done.push_back(NB_IDX'(p));
  endtask

  task automatic push_sweep();
    for (int p = 0; p < N_POINTS; p++) push_point(p, N_SAMPLES, 1'b1);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_wr_en = 1'b0;
    i_wr_addr = '0; i_wr_data = '0; i_valid_I = 1'b1; i_valid_Q = 1'b1;
    step(); step();
    i_reset = 1'b0;
    step();
    @(negedge clk);
    checks += 6;
    if (o_sigma !== 8'h00) begin errors++; $display("FAIL reset_sigma: got %h expected 00", o_sigma); end
    if (o_point !== 3'd0) begin errors++; $display("FAIL reset_point: got %0d expected 0", o_point); end
    if (o_log_en !== 1'b0) begin errors++; $display("FAIL reset_log_en: got %b expected 0", o_log_en); end
    if (o_point_done !== 1'b0) begin errors++; $display("FAIL reset_point_done: got %b expected 0", o_point_done); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
  endtask

  task automatic test_basic_sweep();
    int k;
    push_sweep();
    pulse_start();
    k = 1;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", o_busy); end
    while (o_log_en !== 1'b1 && k < 40) begin step(); k++; @(negedge clk); end
    checks++;
    if (k != 6) begin errors++; $display("FAIL first_log_latency: got %0d expected 6", k); end
    while (o_done !== 1'b1 && k < 200) begin step(); k++; @(negedge clk); end
    checks += 5;
    if (k != 85) begin errors++; $display("FAIL sweep_length: got %0d expected 85", k); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_in_done: got %b expected 0", o_busy); end
    if (o_sigma !== 8'h10) begin errors++; $display("FAIL sigma_in_done: got %h expected 10", o_sigma); end
    if (o_point !== 3'd5) begin errors++; $display("FAIL point_in_done: got %0d expected 5", o_point); end
    if (q_log.size() != 0 || q_done.size() != 0) begin
      errors++; $display("FAIL basic_drain: got %0d/%0d pending expected 0/0", q_log.size(), q_done.size());
    end
  endtask

  task automatic test_table_write();
    int k;
    i_wr_en = 1'b1; i_wr_addr = 3'd2; i_wr_data = 8'h30;
    step();
    i_wr_addr = 3'd7; i_wr_data = 8'h55;
    step();
    i_wr_en = 1'b0;
    tb_tbl[2*8 +: 8] = 8'h30;
    push_sweep();
    pulse_start();
    k = 1;
    @(negedge clk);
    while (o_done !== 1'b1 && k < 200) begin step(); k++; @(negedge clk); end
    checks += 3;
    if (k != 85) begin errors++; $display("FAIL write_sweep_length: got %0d expected 85", k); end
    if (o_sigma !== 8'h10) begin errors++; $display("FAIL write_last_sigma: got %h expected 10", o_sigma); end
    if (q_log.size() != 0 || q_done.size() != 0) begin
      errors++; $display("FAIL write_drain: got %0d/%0d pending expected 0/0", q_log.size(), q_done.size());
    end
  endtask

  task automatic test_start_abort();
    int k;
    // From DONE, abort wins over a simultaneous start.
    i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    @(negedge clk);
    checks += 2;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL done_abort_busy: got %b expected 0", o_busy); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL done_abort_done: got %b expected 0", o_done); end
    step();
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL done_abort_stay_idle: got %b expected 0", o_busy); end
    // Start during SETTLE is ignored; start+abort during COLLECT aborts.
    push_point(0, 2, 1'b0);
    pulse_start();
    k = 1;
    step(); k++;
    i_start = 1'b1;
    step(); k++;
    i_start = 1'b0;
    @(negedge clk);
    while (o_log_en !== 1'b1 && k < 40) begin step(); k++; @(negedge clk); end
    checks++;
    if (k != 6) begin errors++; $display("FAIL settle_start_latency: got %0d expected 6", k); end
    step();
    @(negedge clk);
    i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    @(negedge clk);
    checks += 3;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL collect_abort_busy: got %b expected 0", o_busy); end
    if (o_log_en !== 1'b0) begin errors++; $display("FAIL collect_abort_log: got %b expected 0", o_log_en); end
    if (q_log.size() != 0 || q_done.size() != 0) begin
      errors++; $display("FAIL start_abort_drain: got %0d/%0d pending expected 0/0", q_log.size(), q_done.size());
    end
  endtask

  task automatic test_valid_gap();
    int k, nlog, first, pd;
    push_point(0, N_SAMPLES, 1'b1);
    i_valid_Q = 1'b0;
    pulse_start();
    k = 1; nlog = 0; first = -1; pd = -1;
    i_valid_Q = 1'b1;
    while (k < 60) begin
      @(negedge clk);
      if (o_log_en === 1'b1) begin
        nlog++;
        if (first < 0) first = k;
      end
      if (o_point_done === 1'b1) begin
        pd = k;
        break;
      end
      step(); k++;
      i_valid_Q = k[0];
    end
    checks += 3;
    if (first != 7) begin errors++; $display("FAIL gap_first_log: got %0d expected 7", first); end
    if (nlog != 8) begin errors++; $display("FAIL gap_log_count: got %0d expected 8", nlog); end
    if (pd != 22) begin errors++; $display("FAIL gap_point_done_cycle: got %0d expected 22", pd); end
    i_valid_Q = 1'b1;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    @(negedge clk);
    checks += 2;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL gap_abort_busy: got %b expected 0", o_busy); end
    if (q_log.size() != 0 || q_done.size() != 0) begin
      errors++; $display("FAIL gap_drain: got %0d/%0d pending expected 0/0", q_log.size(), q_done.size());
    end
  endtask

  task automatic test_abort();
    int k, n3;
    for (int p = 0; p < 3; p++) push_point(p, N_SAMPLES, 1'b1);
    push_point(3, 3, 1'b0);
    pulse_start();
    k = 1; n3 = 0;
    while (k < 300) begin
      @(negedge clk);
      if (o_point === 3'd3 && o_log_en === 1'b1) n3++;
      if (n3 == 3) break;
      step(); k++;
    end
    checks++;
    if (n3 != 3) begin errors++; $display("FAIL abort_reach_point3: got %0d logs expected 3", n3); end
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    @(negedge clk);
    checks += 5;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", o_busy); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", o_done); end
    if (o_log_en !== 1'b0) begin errors++; $display("FAIL abort_log_en: got %b expected 0", o_log_en); end
    if (o_sigma !== 8'h14) begin errors++; $display("FAIL abort_sigma_hold: got %h expected 14", o_sigma); end
    if (o_point_done !== 1'b0) begin errors++; $display("FAIL abort_point_done: got %b expected 0", o_point_done); end
    repeat (6) step();
    @(negedge clk);
    checks++;
    if (q_log.size() != 0 || q_done.size() != 0) begin
      errors++; $display("FAIL abort_drain: got %0d/%0d pending expected 0/0", q_log.size(), q_done.size());
    end
    push_sweep();
    pulse_start();
    k = 1;
    step(); k++;
    @(negedge clk);
    checks += 2;
    if (o_sigma !== 8'h1c) begin errors++; $display("FAIL restart_sigma: got %h expected 1c", o_sigma); end
    if (o_point !== 3'd0) begin errors++; $display("FAIL restart_point: got %0d expected 0", o_point); end
    while (o_done !== 1'b1 && k < 200) begin step(); k++; @(negedge clk); end
    checks++;
    if (k != 85 || q_log.size() != 0 || q_done.size() != 0) begin
      errors++; $display("FAIL restart_sweep: got length %0d pending %0d expected 85 and 0", k, q_log.size());
    end
  endtask

  task automatic test_reset_mid();
    int k, n0;
    i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 8'h40;
    step();
    i_wr_en = 1'b0;
    tb_tbl[0 +: 8] = 8'h40;
    push_point(0, 3, 1'b0);
    pulse_start();
    k = 1; n0 = 0;
    while (k < 60) begin
      @(negedge clk);
      if (o_log_en === 1'b1) n0++;
      if (n0 == 3) break;
      step(); k++;
    end
    i_reset = 1'b1;
    step();
    @(negedge clk);
    checks += 7;
    if (n0 != 3) begin errors++; $display("FAIL midreset_logs: got %0d expected 3", n0); end
    if (o_sigma !== 8'h00) begin errors++; $display("FAIL midreset_sigma: got %h expected 00", o_sigma); end
    if (o_point !== 3'd0) begin errors++; $display("FAIL midreset_point: got %0d expected 0", o_point); end
    if (o_log_en !== 1'b0) begin errors++; $display("FAIL midreset_log_en: got %b expected 0", o_log_en); end
    if (o_point_done !== 1'b0) begin errors++; $display("FAIL midreset_point_done: got %b expected 0", o_point_done); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", o_busy); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", o_done); end
    i_reset = 1'b0;
    tb_tbl = DEF_TBL;
    step();
    push_sweep();
    pulse_start();
    k = 1;
    @(negedge clk);
    while (o_done !== 1'b1 && k < 200) begin step(); k++; @(negedge clk); end
    checks += 2;
    if (o_sigma !== 8'h10) begin errors++; $display("FAIL midreset_last_sigma: got %h expected 10", o_sigma); end
    if (k != 85 || q_log.size() != 0 || q_done.size() != 0) begin
      errors++; $display("FAIL midreset_sweep: got length %0d pending %0d expected 85 and 0", k, q_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_table_write();
    test_start_abort();
    test_valid_gap();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
